// File: rtl/acc_arbiter_ctrl.sv
// acc_arbiter_ctrl: round-robin sequencer that shares one external accumulator
// between two requesters. A granted job can first clear the accumulator, then
// streams LEN operands into it over valid/ready. It then returns the sum, a
// sticky overflow flag and a one-cycle done pulse to the owner.
module acc_arbiter_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       req_clr,
  input  logic [CNT_W-1:0] req_len0,
  input  logic [CNT_W-1:0] req_len1,
  input  logic [1:0]       op_valid,
  input  logic [WIDTH-1:0] op_data0,
  input  logic [WIDTH-1:0] op_data1,
  output logic [1:0]       op_ready,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [WIDTH-1:0] acc_in,
  output logic             acc_update,
  input  logic [WIDTH-1:0] acc_out
);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DONE} state_t;

  state_t           state_reg, state_next;
  logic             owner_reg, owner_next;   // requester currently served
  logic             last_reg, last_next;     // requester served most recently
  logic [CNT_W-1:0] cnt_reg, cnt_next;       // operands still to accept
  logic [WIDTH-1:0] result_reg, result_next;
  logic             ovf_reg, ovf_next;

  logic             pick;
  logic             clr_pick;
  logic [CNT_W-1:0] len_pick;
  logic             own_valid;
  logic [WIDTH-1:0] own_data;
  logic [WIDTH:0]   sum;

  // Arbitration choice and the owner's operand path with its carry-out.
  always_comb begin
    pick      = (req == 2'b11) ? ~last_reg : req[1];
    clr_pick  = req_clr[pick];
    len_pick  = pick ? req_len1 : req_len0;
    own_valid = op_valid[owner_reg];
    own_data  = owner_reg ? op_data1 : op_data0;
    sum       = {1'b0, acc_out} + {1'b0, own_data};
  end

  // Next-state logic and the combinational accumulator drive.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    last_next   = last_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    acc_in      = '0;
    acc_update  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          owner_next = pick;
          cnt_next   = len_pick;
          ovf_next   = 1'b0;
          if (clr_pick) begin
            state_next = CLEAR;
          end else if (len_pick != '0) begin
            state_next = ACCUM;
          end else begin
            // Empty job without clear: the accumulator keeps its value.
            state_next  = DONE;
            result_next = acc_out;
          end
        end
      end
      CLEAR: begin
        // Adding the two's-complement negation leaves the accumulator at zero.
        acc_in     = ~acc_out + WIDTH'(1);
        acc_update = 1'b1;
        if (cnt_reg != '0) begin
          state_next = ACCUM;
        end else begin
          state_next  = DONE;
          result_next = '0;
        end
      end
      ACCUM: begin
        if (own_valid) begin
          acc_in     = own_data;
          acc_update = 1'b1;
          cnt_next   = cnt_reg - CNT_W'(1);
          ovf_next   = ovf_reg | sum[WIDTH];
          if (cnt_reg == CNT_W'(1)) begin
            state_next  = DONE;
            result_next = sum[WIDTH-1:0];
          end
        end
      end
      DONE: begin
        last_next  = owner_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; last_reg resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      last_reg   <= 1'b1;
      cnt_reg    <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      last_reg   <= last_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Per-requester decode of grant, ready and done from the state.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign grant[gi]    = (state_reg != IDLE)  && (owner_reg == 1'(gi));
      assign op_ready[gi] = (state_reg == ACCUM) && (owner_reg == 1'(gi));
      assign done[gi]     = (state_reg == DONE)  && (owner_reg == 1'(gi));
    end
  endgenerate

  assign result = result_reg;
  assign ovf    = ovf_reg;

endmodule

// File: tb/tb_acc_arbiter_ctrl.sv
// Bench for acc_arbiter_ctrl: a simple accumulator model stands in for acc.
// Each job is predicted from the arbitration rule and plain arithmetic on a
// bench-side copy of the accumulator value.
module tb_acc_arbiter_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] req, req_clr, op_valid;
  logic [3:0] req_len0, req_len1;
  logic [7:0] op_data0, op_data1;
  logic [1:0] op_ready, grant, done;
  logic [7:0] result, acc_in, acc_out;
  logic       ovf, acc_update;

  int errors = 0;
  int checks = 0;
  int jobs   = 0;

  // Bench-side expectation state.
  logic [7:0] exp_acc = 8'h00;
  int         last_w  = 1;
  logic [7:0] data_tab [16];
  int         stall_tab[16];

  acc_arbiter_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .req(req), .req_clr(req_clr), .req_len0(req_len0), .req_len1(req_len1),
    .op_valid(op_valid), .op_data0(op_data0), .op_data1(op_data1),
    .op_ready(op_ready), .grant(grant), .done(done),
    .result(result), .ovf(ovf),
    .acc_in(acc_in), .acc_update(acc_update), .acc_out(acc_out)
  );

  always #5 clock = ~clock;

  // Stand-in for the shared accumulator, on the same reset net.
  logic [7:0] acc_q;
  always @(posedge clock or posedge reset) begin
    if (reset) acc_q <= 8'h00;
    else if (acc_update) acc_q <= acc_q + acc_in;
  end
  assign acc_out = acc_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Random values on every input the controller must ignore this cycle.
  task automatic scramble(input bit hold, input logic [1:0] rq);
    req      = hold ? rq : 2'($urandom);
    req_clr  = 2'($urandom);
    req_len0 = 4'($urandom);
    req_len1 = 4'($urandom);
    op_valid = 2'($urandom);
    op_data0 = 8'($urandom);
    op_data1 = 8'($urandom);
  endtask

  task automatic drive_own(input int w, input logic v, input logic [7:0] d);
    op_valid[w] = v;
    if (w == 1) op_data1 = d;
    else        op_data0 = d;
  endtask

  // One complete job: request, optional clear, operands with stalls, done.
  task automatic run_job(input logic [1:0] rq, input logic [1:0] clr,
                         input logic [3:0] l0, input logic [3:0] l1,
                         input bit hold, input bit rnd);
    int         w, n, stalls;
    logic [1:0] oh;
    logic [8:0] s;
    logic       eovf;
    logic [7:0] d;
    w    = (rq == 2'b11) ? 1 - last_w : (rq[1] ? 1 : 0);
    n    = (w == 1) ? int'(l1) : int'(l0);
    oh   = (w == 1) ? 2'b10 : 2'b01;
    eovf = 1'b0;
    @(negedge clock);
    req = rq; req_clr = clr; req_len0 = l0; req_len1 = l1; op_valid = 2'b00;
    #1 check("idle_grant", grant, 0);
    check("idle_ready", op_ready, 0);
    if (clr[w]) begin
      @(negedge clock);
      scramble(hold, rq);
      #1 check("clr_grant", grant, oh);
      check("clr_ready", op_ready, 0);
      check("clr_upd", acc_update, 1);
      check("clr_in", acc_in, 8'(~exp_acc + 8'd1));
      exp_acc = 8'h00;
    end
    for (int k = 0; k < n; k++) begin
      stalls = rnd ? int'($urandom_range(0, 2)) : stall_tab[k];
      for (int j = 0; j < stalls; j++) begin
        @(negedge clock);
        scramble(hold, rq);
        drive_own(w, 1'b0, 8'h00);
        #1 check("stall_grant", grant, oh);
        check("stall_ready", op_ready, oh);
        check("stall_upd", acc_update, 0);
        check("stall_done", done, 0);
      end
      d = rnd ? 8'($urandom) : data_tab[k];
      @(negedge clock);
      scramble(hold, rq);
      drive_own(w, 1'b1, d);
      #1 check("op_grant", grant, oh);
      check("op_ready", op_ready, oh);
      check("op_upd", acc_update, 1);
      check("op_in", acc_in, d);
      check("op_done", done, 0);
      s       = {1'b0, exp_acc} + {1'b0, d};
      eovf    = eovf | s[8];
      exp_acc = s[7:0];
    end
    @(negedge clock);
    scramble(hold, rq);
    req = hold ? rq : 2'b00;
    #1 check("done_grant", grant, oh);
    check("done_pulse", done, oh);
    check("done_ready", op_ready, 0);
    check("done_upd", acc_update, 0);
    check("done_result", result, exp_acc);
    check("done_ovf", ovf, eovf);
    check("done_acc", acc_out, exp_acc);
    last_w = w;
    jobs++;
    $display("job %0d: owner=%0d clr=%0d len=%0d result=%02h ovf=%0b",
             jobs, w, clr[w], n, exp_acc, eovf);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req = 0; req_clr = 0; req_len0 = 0; req_len1 = 0;
    op_valid = 0; op_data0 = 0; op_data1 = 0;
    repeat (2) @(negedge clock);
    #1 check("rst_grant", grant, 0);
    check("rst_ready", op_ready, 0);
    check("rst_done", done, 0);
    check("rst_upd", acc_update, 0);
    check("rst_in", acc_in, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;

    // Requester 0 clears, then 10+20+30.
    data_tab[0] = 8'd10; data_tab[1] = 8'd20; data_tab[2] = 8'd30;
    stall_tab[0] = 0; stall_tab[1] = 0; stall_tab[2] = 0;
    run_job(2'b01, 2'b01, 4'd3, 4'd0, 1'b0, 1'b0);
    check("t1_result", result, 8'd60);

    // Requester 1 adds 100+100 on top of 60 and wraps.
    data_tab[0] = 8'd100; data_tab[1] = 8'd100;
    run_job(2'b10, 2'b00, 4'd0, 4'd2, 1'b0, 1'b0);
    check("t2_result", result, 8'd4);
    check("t2_ovf", ovf, 1);

    // Both requesters held high: ownership must alternate.
    data_tab[0] = 8'd1; stall_tab[0] = 0;
    repeat (4) run_job(2'b11, 2'b00, 4'd1, 4'd1, 1'b1, 1'b0);

    // Three stall cycles before the second operand.
    data_tab[0] = 8'd5; data_tab[1] = 8'd6;
    stall_tab[0] = 0; stall_tab[1] = 3;
    run_job(2'b01, 2'b00, 4'd2, 4'd0, 1'b0, 1'b0);

    // Reset in the middle of an accumulate phase.
    @(negedge clock);
    req = 2'b01; req_clr = 2'b00; req_len0 = 4'd5; op_valid = 2'b00;
    @(negedge clock);
    req = 2'b00; op_valid = 2'b01; op_data0 = 8'd7;
    #1 check("t5_ready", op_ready, 2'b01);
    @(negedge clock);
    op_data0 = 8'd9;
    @(negedge clock);
    reset = 1'b1;
    #1 check("t5_grant", grant, 0);
    check("t5_ready0", op_ready, 0);
    check("t5_upd", acc_update, 0);
    check("t5_done", done, 0);
    check("t5_ovf", ovf, 0);
    check("t5_result", result, 0);
    check("t5_acc", acc_out, 0);
    @(negedge clock);
    reset = 1'b0; op_valid = 2'b00;
    #1 check("t5_idle", grant, 0);
    exp_acc = 8'h00;
    last_w  = 1;
    $display("job: reset mid-accumulate, job discarded");

    // Load 0x55, then clear with an empty job.
    data_tab[0] = 8'h55; stall_tab[0] = 0;
    run_job(2'b10, 2'b10, 4'd0, 4'd1, 1'b0, 1'b0);
    run_job(2'b10, 2'b10, 4'd0, 4'd0, 1'b0, 1'b0);
    check("t6_result", result, 8'h00);
    check("t6_ovf", ovf, 0);

    // Randomised jobs.
    for (int i = 0; i < 40; i++) begin
      run_job(2'($urandom_range(1, 3)), 2'($urandom),
              4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)),
              ($urandom_range(0, 3) == 0), 1'b1);
    end

    @(negedge clock);
    req = 2'b00; op_valid = 2'b00;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
